adc_idelay_cal: RTL and testbench
=================================

Name: adc_idelay_cal

Overview:
- Calibration controller for the 8-lane ADC capture path.
- Drives per-lane variable IDELAY taps with CE/INC/RST while the ADC emits a fixed training pattern.
- Sweeps every tap, finds the passing window and parks each lane at the window centre.
- Sits beside the IDELAY/IDDR capture logic in the clk200 domain; the system sequencer starts it before enabling ADC data consumers.

Parameters:
- TAPS, 64, number of IDELAY taps per lane (tap index width 6).
- SETTLE_CYC, 16, idle cycles after any tap change before checking.
- CHECK_CYC, 256, consecutive sample cycles that must all match for a tap to pass.
- PAT1, 8'hFF, expected ad1 lane bits (rising-edge samples).
- PAT2, 8'h00, expected ad2 lane bits (falling-edge samples).

Ports:
- clk200  in  1  controller clock; also the IDELAY control clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begin calibration of all lanes.
- idelay_rdy  in  1  IDELAYCTRL ready.
- ad1  in  8  rising-edge samples, already in the clk200 domain.
- ad2  in  8  falling-edge samples, already in the clk200 domain.
- dly_ce  out  8  per-lane IDELAY CE pulse.
- dly_inc  out  8  per-lane IDELAY INC (increment direction).
- dly_rst  out  8  per-lane IDELAY RST; loads tap 0.
- busy  out  1  calibration in progress.
- done  out  1  set when all lanes have finished; held until next start or RST.
- lane_err  out  8  lane found no passing tap.
- tap_out  out  48  final tap per lane; lane n is at [6n+5:6n].

Behaviour:
- Reset (RST=1 at a clk200 edge):
  - all outputs 0 and tap_out 0; FSM returns to IDLE, including when reset arrives mid-sweep.
  - Taps left mid-sweep are not restored.
- States: IDLE, WAIT_RDY, TAP_RST, SETTLE, CHECK, STEP, CENTER_RST, CENTER_STEP, NEXT_LANE, FIN.
- IDLE:
  - start=1 -> WAIT_RDY; busy=1, done=0, lane_err=0, lane=0.
  - start while busy is ignored.
- WAIT_RDY: stay until idelay_rdy=1, then -> TAP_RST.
- TAP_RST: dly_rst[lane]=1 for 1 cycle; tap=0 -> SETTLE.
- SETTLE: count SETTLE_CYC cycles -> CHECK.
- CHECK:
  - Runs for CHECK_CYC cycles. A sample fails if ad1[lane]!=PAT1[lane] or ad2[lane]!=PAT2[lane].
  - The tap passes only if no sample failed.
  - At the end of CHECK, update the window:
    - the first pass records lo=hi=tap;
    - each subsequent contiguous pass sets hi=tap;
    - the first fail after a window closes it, and later passes are ignored.
  - If tap==TAPS-1 -> CENTER_RST, else -> STEP.
- STEP: dly_ce[lane]=dly_inc[lane]=1 for exactly 1 cycle; tap+1 -> SETTLE.
- CENTER_RST:
  - No pass found: lane_err[lane]=1, tap_out lane=0, pulse dly_rst -> NEXT_LANE.
  - Otherwise: centre=(lo+hi)>>1 (7-bit sum, floor), pulse dly_rst -> CENTER_STEP.
- CENTER_STEP:
  - Issue centre CE/INC pulses, each followed by 2 idle cycles.
  - centre=0 issues no pulses.
  - Then write tap_out lane=centre -> NEXT_LANE.
- NEXT_LANE: lane==7 -> FIN, else lane+1 -> TAP_RST.
- FIN: busy=0, done=1 -> IDLE.
- Output rules:
  - dly_ce, dly_inc and dly_rst are registered.
  - Only the current lane's bit is ever non-zero.
  - No CE and RST in the same cycle.
- Boundaries:
  - A window extending to tap TAPS-1 closes with hi=TAPS-1.
  - A single passing tap gives centre=that tap.
  - Pass at tap 0 gives lo=0.
- Latency per lane ≈ TAPS*(SETTLE_CYC+CHECK_CYC+1)+3*centre+small constant.

Optional Feature:
- Macro ADC_CAL_LONGEST_WINDOW_EN.
- Defined:
  - Sweep tracks every contiguous pass run and keeps the longest; the earliest run wins ties.
  - Centre uses that run.
- Undefined: the first contiguous run is used; later runs are ignored.

Test Plan:
- start with idelay_rdy=0 for 50 cycles -> busy=1, no dly_* activity until rdy rises; then dly_rst[0] pulses once.
- Model passes lane 0 at taps 10..20 only, all other lanes 30..31 -> tap_out lane0=15, lanes1-7=30, done=1, lane_err=0; lane0 gets exactly 15 CE pulses after centre reset.
- Lane 3 never passes -> lane_err=8'h08, tap_out lane3=0, other lanes calibrate, done=1.
- Lane 5 passes taps 5..7 and 40..63 -> macro off: tap_out lane5=6; macro on: tap_out lane5=51.
- Assert RST mid-CHECK of lane 2 -> next cycle all outputs 0, FSM IDLE; a new start recalibrates from lane 0.
- Lane passes only at tap 63 -> centre=63, 63 CE pulses; start pulse issued during busy has no effect.

Source files
------------

// File: rtl/adc_idelay_cal.sv
// adc_idelay_cal: IDELAY tap calibration controller for the 8-lane ADC capture path.
//
// While the ADC drives a fixed training pattern, each lane is swept in turn across
// every IDELAY tap. A tap passes when CHECK_CYC consecutive samples all match
// PAT1 (rising edge, ad1) and PAT2 (falling edge, ad2) for that lane. The lane is
// then reset to tap 0 and stepped up to the centre of the passing window.
//
// Ports:
//   clk200      controller clock, also the IDELAY control clock
//   RST         synchronous active-high reset
//   start       one-cycle pulse, calibrate all lanes (ignored while busy)
//   idelay_rdy  IDELAYCTRL ready
//   ad1, ad2    rising / falling edge samples, already in the clk200 domain
//   dly_ce      per-lane IDELAY CE pulse (registered)
//   dly_inc     per-lane IDELAY INC (registered, always with CE)
//   dly_rst     per-lane IDELAY RST, loads tap 0 (registered)
//   busy        calibration in progress
//   done        all lanes finished, held until next start or RST
//   lane_err    lane found no passing tap
//   tap_out     final tap per lane, lane n at [TW*n +: TW]
//
// Build option: define ADC_CAL_LONGEST_WINDOW_EN to centre on the longest contiguous
// passing run (earliest wins ties). Without it the first contiguous run is used.

module adc_idelay_cal #(
    parameter int unsigned TAPS       = 64,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned CHECK_CYC  = 256,
    parameter logic [7:0]  PAT1       = 8'hFF,
    parameter logic [7:0]  PAT2       = 8'h00
) (
    input  logic                      clk200,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      idelay_rdy,
    input  logic [7:0]                ad1,
    input  logic [7:0]                ad2,
    output logic [7:0]                dly_ce,
    output logic [7:0]                dly_inc,
    output logic [7:0]                dly_rst,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                lane_err,
    output logic [8*$clog2(TAPS)-1:0] tap_out
);

    localparam int unsigned TW      = $clog2(TAPS);
    localparam int unsigned CNT_MAX = (CHECK_CYC > SETTLE_CYC) ? CHECK_CYC : SETTLE_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYC - 1);
    // Idle cycles after each centring CE pulse.
    localparam logic [CW-1:0] STEP_GAP    = CW'(2);
    localparam logic [TW-1:0] TAP_LAST    = TW'(TAPS - 1);

    localparam logic [3:0] StIdle       = 4'd0;
    localparam logic [3:0] StWaitRdy    = 4'd1;
    localparam logic [3:0] StTapRst     = 4'd2;
    localparam logic [3:0] StSettle     = 4'd3;
    localparam logic [3:0] StCheck      = 4'd4;
    localparam logic [3:0] StStep       = 4'd5;
    localparam logic [3:0] StCenterRst  = 4'd6;
    localparam logic [3:0] StCenterStep = 4'd7;
    localparam logic [3:0] StNextLane   = 4'd8;
    localparam logic [3:0] StFin        = 4'd9;

    logic [3:0]      state_q, state_d;
    logic [2:0]      lane_q, lane_d;
    logic [TW-1:0]   tap_q, tap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fail_q, fail_d;
    logic            found_q, found_d;
    logic [TW-1:0]   lo_q, lo_d;
    logic [TW-1:0]   hi_q, hi_d;
    logic [TW-1:0]   centre_q, centre_d;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
    logic            run_act_q, run_act_d;
    logic [TW-1:0]   run_lo_q, run_lo_d;
    logic [TW-1:0]   run_lo_eff;
`else
    logic            closed_q, closed_d;
`endif
    logic [7:0]      dly_ce_q, dly_ce_d;
    logic [7:0]      dly_inc_q, dly_inc_d;
    logic [7:0]      dly_rst_q, dly_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      lane_err_q, lane_err_d;
    logic [8*TW-1:0] tap_out_q, tap_out_d;

    logic            samp_fail;
    logic            tap_pass;
    logic [TW:0]     win_sum;
    logic [TW-1:0]   centre_w;

    assign samp_fail = (ad1[lane_q] != PAT1[lane_q]) || (ad2[lane_q] != PAT2[lane_q]);
    // Valid only on the last CHECK cycle: this sample plus every earlier one.
    assign tap_pass  = !(fail_q || samp_fail);
    // One extra bit so lo+hi cannot overflow before the halving.
    assign win_sum   = {1'b0, lo_q} + {1'b0, hi_q};
    assign centre_w  = win_sum[TW:1];

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        tap_d      = tap_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        found_d    = found_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        centre_d   = centre_q;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
        run_act_d  = run_act_q;
        run_lo_d   = run_lo_q;
        run_lo_eff = run_act_q ? run_lo_q : tap_q;
`else
        closed_d   = closed_q;
`endif
        dly_ce_d   = '0;
        dly_inc_d  = '0;
        dly_rst_d  = '0;
        busy_d     = busy_q;
        done_d     = done_q;
        lane_err_d = lane_err_q;
        tap_out_d  = tap_out_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StWaitRdy;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    lane_err_d = '0;
                    lane_d     = '0;
                end
            end

            StWaitRdy: begin
                if (idelay_rdy) begin
                    state_d = StTapRst;
                end
            end

            StTapRst: begin
                dly_rst_d[lane_q] = 1'b1;
                tap_d             = '0;
                cnt_d             = '0;
                fail_d            = 1'b0;
                found_d           = 1'b0;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
                run_act_d         = 1'b0;
`else
                closed_d          = 1'b0;
`endif
                state_d           = StSettle;
            end

            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StCheck: begin
                fail_d = fail_q | samp_fail;
                if (cnt_q == CHECK_LAST) begin
                    cnt_d = '0;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
                    // Extend the current run; replace the best only when strictly longer,
                    // so the earliest of equal-length runs is kept.
                    if (tap_pass) begin
                        run_act_d = 1'b1;
                        run_lo_d  = run_lo_eff;
                        if (!found_q || ((tap_q - run_lo_eff) > (hi_q - lo_q))) begin
                            found_d = 1'b1;
                            lo_d    = run_lo_eff;
                            hi_d    = tap_q;
                        end
                    end else begin
                        run_act_d = 1'b0;
                    end
`else
                    // First run only: once a fail follows a pass the window is frozen.
                    if (tap_pass) begin
                        if (!found_q) begin
                            found_d = 1'b1;
                            lo_d    = tap_q;
                            hi_d    = tap_q;
                        end else if (!closed_q) begin
                            hi_d = tap_q;
                        end
                    end else if (found_q) begin
                        closed_d = 1'b1;
                    end
`endif
                    state_d = (tap_q == TAP_LAST) ? StCenterRst : StStep;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStep: begin
                dly_ce_d[lane_q]  = 1'b1;
                dly_inc_d[lane_q] = 1'b1;
                tap_d             = tap_q + 1'b1;
                cnt_d             = '0;
                state_d           = StSettle;
            end

            StCenterRst: begin
                dly_rst_d[lane_q] = 1'b1;
                tap_d             = '0;
                cnt_d             = '0;
                if (!found_q) begin
                    lane_err_d[lane_q]                = 1'b1;
                    tap_out_d[32'(lane_q) * TW +: TW] = '0;
                    state_d                           = StNextLane;
                end else begin
                    centre_d = centre_w;
                    state_d  = StCenterStep;
                end
            end

            StCenterStep: begin
                // tap_q counts the CE pulses issued since the centring reset.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (tap_q != centre_q) begin
                    dly_ce_d[lane_q]  = 1'b1;
                    dly_inc_d[lane_q] = 1'b1;
                    tap_d             = tap_q + 1'b1;
                    cnt_d             = STEP_GAP;
                end else begin
                    tap_out_d[32'(lane_q) * TW +: TW] = centre_q;
                    state_d                           = StNextLane;
                end
            end

            StNextLane: begin
                if (lane_q == 3'd7) begin
                    state_d = StFin;
                end else begin
                    lane_d  = lane_q + 1'b1;
                    state_d = StTapRst;
                end
            end

            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk200) begin
        if (RST) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            tap_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            found_q    <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            centre_q   <= '0;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
            run_act_q  <= 1'b0;
            run_lo_q   <= '0;
`else
            closed_q   <= 1'b0;
`endif
            dly_ce_q   <= '0;
            dly_inc_q  <= '0;
            dly_rst_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lane_err_q <= '0;
            tap_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            found_q    <= found_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            centre_q   <= centre_d;
`ifdef ADC_CAL_LONGEST_WINDOW_EN
            run_act_q  <= run_act_d;
            run_lo_q   <= run_lo_d;
`else
            closed_q   <= closed_d;
`endif
            dly_ce_q   <= dly_ce_d;
            dly_inc_q  <= dly_inc_d;
            dly_rst_q  <= dly_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lane_err_q <= lane_err_d;
            tap_out_q  <= tap_out_d;
        end
    end

    assign dly_ce   = dly_ce_q;
    assign dly_inc  = dly_inc_q;
    assign dly_rst  = dly_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign lane_err = lane_err_q;
    assign tap_out  = tap_out_q;

endmodule

// File: tb/tb_adc_idelay_cal.sv
`timescale 1ns/1ps
module tb_adc_idelay_cal;

    localparam int unsigned TAPS       = 64;
    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned CHECK_CYC  = 4;
    localparam logic [7:0]  PAT1       = 8'hFF;
    localparam logic [7:0]  PAT2       = 8'h00;

`ifdef ADC_CAL_LONGEST_WINDOW_EN
    localparam logic [5:0] LANE5_EXP = 6'd51;
`else
    localparam logic [5:0] LANE5_EXP = 6'd6;
`endif

    logic        clk200     = 1'b0;
    logic        RST        = 1'b1;
    logic        start      = 1'b0;
    logic        idelay_rdy = 1'b0;
    logic [7:0]  ad1, ad2;
    logic [7:0]  dly_ce, dly_inc, dly_rst, lane_err;
    logic        busy, done;
    logic [47:0] tap_out;

    adc_idelay_cal #(
        .TAPS       (TAPS),
        .SETTLE_CYC (SETTLE_CYC),
        .CHECK_CYC  (CHECK_CYC),
        .PAT1       (PAT1),
        .PAT2       (PAT2)
    ) dut (
        .clk200     (clk200),
        .RST        (RST),
        .start      (start),
        .idelay_rdy (idelay_rdy),
        .ad1        (ad1),
        .ad2        (ad2),
        .dly_ce     (dly_ce),
        .dly_inc    (dly_inc),
        .dly_rst    (dly_rst),
        .busy       (busy),
        .done       (done),
        .lane_err   (lane_err),
        .tap_out    (tap_out)
    );

    always #2.5 clk200 = ~clk200;

    // IDELAY + training-pattern model: each lane's tap follows dly_rst/dly_ce/dly_inc,
    // and the lane shows the correct pattern only at taps set in pass_mask.
    logic [7:0][63:0] pass_mask = '0;
    logic [7:0][5:0]  mtap      = '0;
    logic             mon_clr   = 1'b0;
    logic [7:0][6:0]  ce_cnt    = '0;
    logic [7:0][3:0]  rst_cnt   = '0;
    int               act_cnt   = 0;
    int               viol_cnt  = 0;

    always @(posedge clk200) begin
        for (int l = 0; l < 8; l++) begin
            if (dly_rst[l]) mtap[l] <= '0;
            else if (dly_ce[l] && dly_inc[l]) mtap[l] <= mtap[l] + 6'd1;
        end
        if (mon_clr) begin
            ce_cnt   <= '0;
            rst_cnt  <= '0;
            act_cnt  <= 0;
            viol_cnt <= 0;
        end else begin
            for (int l = 0; l < 8; l++) begin
                if (dly_rst[l]) begin
                    ce_cnt[l]  <= '0;
                    rst_cnt[l] <= rst_cnt[l] + 4'd1;
                end else if (dly_ce[l]) begin
                    ce_cnt[l]  <= ce_cnt[l] + 7'd1;
                end
            end
            if ((dly_ce | dly_inc | dly_rst) != 8'h00) act_cnt <= act_cnt + 1;
            if (($countones(dly_ce | dly_rst) > 1) || ((dly_ce & dly_rst) != 8'h00) ||
                (dly_inc != dly_ce)) viol_cnt <= viol_cnt + 1;
        end
    end

    always_comb begin
        ad1 = '0;
        ad2 = '0;
        for (int l = 0; l < 8; l++) begin
            ad1[l] = pass_mask[l][mtap[l]] ? PAT1[l] : ~PAT1[l];
            ad2[l] = pass_mask[l][mtap[l]] ? PAT2[l] : ~PAT2[l];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0][63:0] mask;
        logic [7:0][5:0]  exp_tap;
        logic [7:0]       exp_err;
        logic [7:0]       rdy_delay;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [63:0] win(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic vec_t base_vec();
        vec_t v;
        for (int l = 0; l < 8; l++) begin
            v.mask[l]    = win(30, 31);
            v.exp_tap[l] = 6'd30;
        end
        v.exp_err   = 8'h00;
        v.rdy_delay = 8'd3;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk200);
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        pass_mask  = v.mask;
        idelay_rdy = 1'b0;
        @(negedge clk200);
        mon_clr = 1'b1;
        start   = 1'b1;
        @(negedge clk200);
        mon_clr = 1'b0;
        start   = 1'b0;
        check($sformatf("v%0d_busy_after_start", idx), busy, 1);
        check($sformatf("v%0d_done_cleared", idx), done, 0);
        repeat (int'(v.rdy_delay)) @(negedge clk200);
        check($sformatf("v%0d_busy_wait_rdy", idx), busy, 1);
        check($sformatf("v%0d_no_activity_before_rdy", idx), act_cnt, 0);
        idelay_rdy = 1'b1;
        n = 0;
        while (((dly_ce | dly_inc | dly_rst) == 8'h00) && n < 100) begin
            @(negedge clk200);
            n++;
        end
        check($sformatf("v%0d_first_activity", idx), {dly_ce, dly_inc, dly_rst}, 24'h000001);
        @(negedge clk200);
        check($sformatf("v%0d_rst_single_cycle", idx), dly_rst, 8'h00);
        // A start mid-calibration must not restart the sweep.
        repeat (600) @(negedge clk200);
        check($sformatf("v%0d_busy_mid", idx), busy, 1);
        pulse_start();
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk200);
            n++;
        end
        check($sformatf("v%0d_done_in_time", idx), done, 1);
        repeat (5) @(negedge clk200);
        check($sformatf("v%0d_done_held", idx), done, 1);
        check($sformatf("v%0d_busy_clear", idx), busy, 0);
        check($sformatf("v%0d_lane_err", idx), lane_err, v.exp_err);
        check($sformatf("v%0d_tap_out", idx), tap_out, v.exp_tap);
        check($sformatf("v%0d_model_taps", idx), mtap, v.exp_tap);
        for (int l = 0; l < 8; l++) begin
            check($sformatf("v%0d_ce_after_centre_rst_lane%0d", idx, l), ce_cnt[l],
                  {1'b0, v.exp_tap[l]});
            check($sformatf("v%0d_rst_pulses_lane%0d", idx, l), rst_cnt[l], 4'd2);
        end
        check($sformatf("v%0d_ctrl_rule_violations", idx), viol_cnt, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int n;
        vec_t v;

        v = base_vec();
        v.mask[0] = win(10, 20); v.exp_tap[0] = 6'd15; v.rdy_delay = 8'd50;
        vecs[0] = v;
        v = base_vec();
        v.mask[3] = '0; v.exp_tap[3] = 6'd0; v.exp_err = 8'h08;
        vecs[1] = v;
        v = base_vec();
        v.mask[5] = win(5, 7) | win(40, 63); v.exp_tap[5] = LANE5_EXP;
        vecs[2] = v;
        v = base_vec();
        v.mask[0] = win(63, 63); v.exp_tap[0] = 6'd63;
        v.mask[1] = win(0, 0);   v.exp_tap[1] = 6'd0;
        v.mask[2] = win(0, 63);  v.exp_tap[2] = 6'd31;
        v.mask[3] = win(20, 20); v.exp_tap[3] = 6'd20;
        vecs[3] = v;

        // Reset state
        repeat (3) @(negedge clk200);
        RST = 1'b0;
        @(negedge clk200);
        check("reset_outputs", {dly_ce, dly_inc, dly_rst, busy, done, lane_err}, 0);
        check("reset_tap_out", tap_out, 0);

        // Reset in the middle of lane 2's CHECK phase
        pass_mask  = vecs[0].mask;
        idelay_rdy = 1'b1;
        pulse_start();
        n = 0;
        while (!dly_rst[2] && n < 5000) begin
            @(negedge clk200);
            n++;
        end
        check("lane2_sweep_reached", dly_rst[2], 1);
        repeat (3) @(negedge clk200);
        check("pre_reset_tap_out", tap_out, {6'd30, 6'd15});
        RST = 1'b1;
        @(negedge clk200);
        RST = 1'b0;
        check("midrun_reset_outputs", {dly_ce, dly_inc, dly_rst, busy, done, lane_err}, 0);
        check("midrun_reset_tap_out", tap_out, 0);
        mon_clr = 1'b1;
        @(negedge clk200);
        mon_clr = 1'b0;
        repeat (20) @(negedge clk200);
        check("idle_after_reset_activity", act_cnt, 0);
        check("idle_after_reset_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
